// File: rtl/mem_req_arbiter_if.sv
// Bundle of the two requester ports (instruction fetch and data access)
// and the shared memory-side port of the request arbiter.
// The slave modport is the arbiter's view; the master modport is the view
// of everything around it (requesters plus the downstream bridge).
interface mem_req_arbiter_if;

    // Instruction-fetch requester
    logic        inst_req;
    logic        inst_wr;
    logic [1:0]  inst_size;
    logic [3:0]  inst_wstrb;
    logic [31:0] inst_addr;
    logic [31:0] inst_wdata;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    // Data-access requester
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    // Shared memory-side port
    logic        mem_req;
    logic        mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;

    modport slave (
        input  inst_req, inst_wr, inst_size, inst_wstrb, inst_addr, inst_wdata,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        input  data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata,
        output mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata,
        input  mem_addr_ok, mem_data_ok, mem_rdata
    );

    modport master (
        output inst_req, inst_wr, inst_size, inst_wstrb, inst_addr, inst_wdata,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        output data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata,
        input  mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata,
        output mem_addr_ok, mem_data_ok, mem_rdata
    );

endinterface

// File: rtl/mem_req_arbiter.sv
// Two-requester arbiter for one SRAM-like split-transaction memory port.
// Data access has strict priority over instruction fetch. A grant is held
// until its address handshake completes, and an owner FIFO remembers which
// requester issued each outstanding transaction so that in-order responses
// are steered back to the right requester with no added latency.
module mem_req_arbiter #(
    parameter int OUTST_DEPTH = 4
) (
    input  logic          clk,
    input  logic          resetn,
    mem_req_arbiter_if.slave bus
);

    localparam int PW = (OUTST_DEPTH > 1) ? $clog2(OUTST_DEPTH) : 1;
    localparam int CW = $clog2(OUTST_DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(OUTST_DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_I = 2'd1,
        LOCK_D = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic [CW-1:0]     r_cnt;
    logic [PW-1:0]     r_wrPtr;
    logic [PW-1:0]     r_rdPtr;
    logic [OUTST_DEPTH-1:0] r_owner;

    logic              w_grantI;
    logic              w_grantD;
    logic              w_notFull;
    logic              w_push;
    logic              w_pop;
    logic              w_head;

    // The grant looks only at the registered count, so a pop in the same
    // cycle never opens a slot for a new grant.
    assign w_notFull = (r_cnt < FULL_CNT);

    // Grant selection and next state; everything is forced idle while
    // resetn is low so the outputs are quiet the moment reset is asserted.
    always_comb begin
        w_grantI    = 1'b0;
        w_grantD    = 1'b0;
        w_nextState = r_state;
        if (resetn) begin
            case (r_state)
                IDLE: begin
                    if (w_notFull) begin
                        if (bus.data_req) begin
                            w_grantD = 1'b1;
                            if (!bus.mem_addr_ok) begin
                                w_nextState = LOCK_D;
                            end
                        end else if (bus.inst_req) begin
                            w_grantI = 1'b1;
                            if (!bus.mem_addr_ok) begin
                                w_nextState = LOCK_I;
                            end
                        end
                    end
                end
                LOCK_I: begin
                    w_grantI = 1'b1;
                    if (bus.inst_req && bus.mem_addr_ok) begin
                        w_nextState = IDLE;
                    end
                end
                LOCK_D: begin
                    w_grantD = 1'b1;
                    if (bus.data_req && bus.mem_addr_ok) begin
                        w_nextState = IDLE;
                    end
                end
                default: begin
                    w_nextState = IDLE;
                end
            endcase
        end
    end

    // Shared port mux: request comes from the granted requester, payload
    // follows the data side when it holds the grant and instruction otherwise.
    always_comb begin
        bus.mem_req   = (w_grantI & bus.inst_req) | (w_grantD & bus.data_req);
        bus.mem_wr    = bus.inst_wr;
        bus.mem_size  = bus.inst_size;
        bus.mem_wstrb = bus.inst_wstrb;
        bus.mem_addr  = bus.inst_addr;
        bus.mem_wdata = bus.inst_wdata;
        if (w_grantD) begin
            bus.mem_wr    = bus.data_wr;
            bus.mem_size  = bus.data_size;
            bus.mem_wstrb = bus.data_wstrb;
            bus.mem_addr  = bus.data_addr;
            bus.mem_wdata = bus.data_wdata;
        end
    end

    assign w_push = bus.mem_req & bus.mem_addr_ok;
    assign w_pop  = bus.mem_data_ok & (r_cnt != '0);
    assign w_head = r_owner[r_rdPtr];

    // Requester-facing handshakes: address acceptance to the grant holder,
    // responses to the owner at the FIFO head, read data to both sides.
    always_comb begin
        bus.inst_addr_ok = w_grantI & bus.inst_req & bus.mem_addr_ok;
        bus.data_addr_ok = w_grantD & bus.data_req & bus.mem_addr_ok;
        bus.inst_data_ok = w_pop & ~w_head;
        bus.data_data_ok = w_pop & w_head;
        bus.inst_rdata   = bus.mem_rdata;
        bus.data_rdata   = bus.mem_rdata;
    end

    // Grant-lock state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Owner FIFO and outstanding count; a simultaneous push and pop leaves
    // the count alone while both pointers advance and wrap naturally.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt   <= '0;
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_owner <= '0;
        end else begin
            if (w_push) begin
                r_owner[r_wrPtr] <= w_grantD;
                r_wrPtr          <= r_wrPtr + PW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + CW'(1);
            end else if (w_pop && !w_push) begin
                r_cnt <= r_cnt - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Bench for mem_req_arbiter: directed cycles with an owner scoreboard.
// Each driven cycle states which requester should hold the grant; an
// expected address handshake pushes that owner, and each response pops the
// oldest owner to decide which data_ok must fire.
module tb_mem_req_arbiter;

    logic clk = 1'b0;
    logic resetn;

    mem_req_arbiter_if bus();

    mem_req_arbiter #(.OUTST_DEPTH(4)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int assertCount = 0;
    int failCount   = 0;
    bit sbOwner[$];

    logic [31:0] iAddr, dAddr, iWdata, dWdata;
    logic        iWr, dWr;
    logic [1:0]  iSize, dSize;
    logic [3:0]  iWstrb, dWstrb;

    // Free-running clock.
    always #5 clk = ~clk;

    // Hard stop in case something wedges the stimulus thread.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Drive one cycle (called just after a rising edge), check on the
    // falling edge, update the scoreboard, then move to the next cycle.
    // expGrant: 0 = nobody, 1 = instruction fetch, 2 = data access.
    task automatic applyStimulus(input string tag, input logic iReq, input logic dReq,
                                 input logic aOk, input logic dOk,
                                 input logic [31:0] rdata, input int expGrant);
        bit owner;
        logic expI, expD;
        bus.inst_req    = iReq;
        bus.inst_wr     = iWr;
        bus.inst_size   = iSize;
        bus.inst_wstrb  = iWstrb;
        bus.inst_addr   = iAddr;
        bus.inst_wdata  = iWdata;
        bus.data_req    = dReq;
        bus.data_wr     = dWr;
        bus.data_size   = dSize;
        bus.data_wstrb  = dWstrb;
        bus.data_addr   = dAddr;
        bus.data_wdata  = dWdata;
        bus.mem_addr_ok = aOk;
        bus.mem_data_ok = dOk;
        bus.mem_rdata   = rdata;
        @(negedge clk);
        checkOutput({tag, " mem_req"}, 32'(bus.mem_req), 32'(expGrant != 0));
        if (expGrant == 2) begin
            checkOutput({tag, " mem_addr"}, bus.mem_addr, dAddr);
            checkOutput({tag, " mem_wr"}, 32'(bus.mem_wr), 32'(dWr));
            checkOutput({tag, " mem_wstrb"}, 32'(bus.mem_wstrb), 32'(dWstrb));
            checkOutput({tag, " mem_wdata"}, bus.mem_wdata, dWdata);
        end else if (expGrant == 1) begin
            checkOutput({tag, " mem_addr"}, bus.mem_addr, iAddr);
            checkOutput({tag, " mem_wr"}, 32'(bus.mem_wr), 32'(iWr));
            checkOutput({tag, " mem_size"}, 32'(bus.mem_size), 32'(iSize));
        end
        checkOutput({tag, " inst_addr_ok"}, 32'(bus.inst_addr_ok), 32'(expGrant == 1 && aOk));
        checkOutput({tag, " data_addr_ok"}, 32'(bus.data_addr_ok), 32'(expGrant == 2 && aOk));
        expI = 1'b0;
        expD = 1'b0;
        if (dOk && sbOwner.size() > 0) begin
            owner = sbOwner.pop_front();
            expI  = !owner;
            expD  = owner;
            if (owner) checkOutput({tag, " data_rdata"}, bus.data_rdata, rdata);
            else       checkOutput({tag, " inst_rdata"}, bus.inst_rdata, rdata);
        end
        checkOutput({tag, " inst_data_ok"}, 32'(bus.inst_data_ok), 32'(expI));
        checkOutput({tag, " data_data_ok"}, 32'(bus.data_data_ok), 32'(expD));
        if (expGrant != 0 && aOk) begin
            sbOwner.push_back(expGrant == 2);
        end
        @(posedge clk);
        #1;
    endtask

    // Drive all inputs to idle values.
    task automatic clearInputs();
        bus.inst_req = 1'b0;   bus.data_req = 1'b0;
        bus.inst_wr = 1'b0;    bus.data_wr = 1'b0;
        bus.inst_size = 2'd2;  bus.data_size = 2'd2;
        bus.inst_wstrb = 4'h0; bus.data_wstrb = 4'h0;
        bus.inst_addr = '0;    bus.data_addr = '0;
        bus.inst_wdata = '0;   bus.data_wdata = '0;
        bus.mem_addr_ok = 1'b0;
        bus.mem_data_ok = 1'b0;
        bus.mem_rdata = '0;
    endtask

    // Quiet-output check while reset is held, with every input shouting.
    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, " mem_req"}, 32'(bus.mem_req), 32'(0));
        checkOutput({tag, " inst_addr_ok"}, 32'(bus.inst_addr_ok), 32'(0));
        checkOutput({tag, " data_addr_ok"}, 32'(bus.data_addr_ok), 32'(0));
        checkOutput({tag, " inst_data_ok"}, 32'(bus.inst_data_ok), 32'(0));
        checkOutput({tag, " data_data_ok"}, 32'(bus.data_data_ok), 32'(0));
    endtask

    // Main directed sequence.
    initial begin
        int iR, dR, eg;
        logic dO;
        iAddr = 32'h1c000000; dAddr = 32'h1c080000;
        iWdata = 32'h0;       dWdata = 32'h11223344;
        iWr = 1'b0;           dWr = 1'b0;
        iSize = 2'd2;         dSize = 2'd2;
        iWstrb = 4'h0;        dWstrb = 4'h0;
        clearInputs();
        resetn = 1'b0;

        // Reset state: outputs quiet even with requests and handshakes present
        #2;
        bus.inst_req = 1'b1; bus.data_req = 1'b1;
        bus.mem_addr_ok = 1'b1; bus.mem_data_ok = 1'b1;
        #1;
        checkResetOutputs("reset");
        clearInputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // Single read
        iAddr = 32'h1c000000;
        applyStimulus("rd c0", 1, 0, 1, 0, 32'h0, 1);
        applyStimulus("rd c1", 0, 0, 0, 0, 32'h0, 0);
        applyStimulus("rd c2", 0, 0, 0, 1, 32'h02800404, 0);
        applyStimulus("rd spur", 0, 0, 0, 1, 32'hdeadbeef, 0);

        // Contention: data write wins, instruction follows
        dAddr = 32'h1c080000; dWr = 1'b1; dWstrb = 4'hf; iAddr = 32'h1c000004;
        applyStimulus("cont c0", 1, 1, 1, 0, 32'h0, 2);
        applyStimulus("cont c1", 1, 0, 1, 0, 32'h0, 1);
        applyStimulus("cont r0", 0, 0, 0, 1, 32'h0000aaaa, 0);
        applyStimulus("cont r1", 0, 0, 0, 1, 32'h0000bbbb, 0);

        // Lock hold: data grant held while instruction request rises
        dAddr = 32'h1c080040; dWr = 1'b0; dWstrb = 4'h0; iAddr = 32'h1c000008;
        applyStimulus("lock c0", 0, 1, 0, 0, 32'h0, 2);
        applyStimulus("lock c1", 1, 1, 0, 0, 32'h0, 2);
        applyStimulus("lock c2", 1, 1, 0, 0, 32'h0, 2);
        applyStimulus("lock c3", 1, 1, 1, 0, 32'h0, 2);
        applyStimulus("lock c4", 1, 0, 1, 0, 32'h0, 1);
        applyStimulus("lock r0", 0, 0, 0, 1, 32'h12345678, 0);
        applyStimulus("lock r1", 0, 0, 0, 1, 32'h9abcdef0, 0);

        // Full: four outstanding, fifth blocked until the cycle after a pop
        for (int k = 0; k < 4; k++) begin
            iAddr = 32'h1c000100 + 32'(4 * k);
            applyStimulus($sformatf("full push%0d", k), 1, 0, 1, 0, 32'h0, 1);
        end
        iAddr = 32'h1c000200;
        applyStimulus("full blk0", 1, 0, 1, 0, 32'h0, 0);
        applyStimulus("full blk1", 1, 1, 1, 0, 32'h0, 0);
        applyStimulus("full popblk", 1, 0, 1, 1, 32'hcafe0001, 0);
        applyStimulus("full grant", 1, 0, 1, 0, 32'h0, 1);
        for (int k = 0; k < 4; k++) begin
            applyStimulus($sformatf("full drain%0d", k), 0, 0, 0, 1, 32'hcafe0010 + 32'(k), 0);
        end

        // Pointer wrap: pseudo-random mix of requests and responses
        dWr = 1'b1; dWstrb = 4'h3;
        for (int k = 0; k < 24; k++) begin
            iR = int'($urandom_range(0, 1));
            dR = int'($urandom_range(0, 1));
            dO = (sbOwner.size() > 0) && ($urandom_range(0, 2) != 0);
            iAddr  = 32'h1c001000 + 32'(4 * k);
            dAddr  = 32'h1c081000 + 32'(4 * k);
            dWdata = 32'h5a000000 + 32'(k);
            if (sbOwner.size() >= 4) eg = 0;
            else if (dR != 0)        eg = 2;
            else if (iR != 0)        eg = 1;
            else                     eg = 0;
            applyStimulus($sformatf("wrap c%0d", k), iR[0], dR[0], 1, dO,
                          32'h77000000 + 32'(k), eg);
        end
        for (int k = 0; k < 8 && sbOwner.size() > 0; k++) begin
            applyStimulus($sformatf("wrap drain%0d", k), 0, 0, 0, 1, 32'h66000000 + 32'(k), 0);
        end
        checkOutput("wrap drained", 32'(sbOwner.size()), 32'(0));

        // Simultaneous push and pop at two outstanding
        dWr = 1'b0; dWstrb = 4'h0;
        applyStimulus("sim c0", 0, 1, 1, 0, 32'h0, 2);
        applyStimulus("sim c1", 1, 0, 1, 0, 32'h0, 1);
        applyStimulus("sim pushpop", 0, 1, 1, 1, 32'hd0d0d0d0, 2);
        applyStimulus("sim c3", 1, 0, 1, 0, 32'h0, 1);
        applyStimulus("sim c4", 1, 0, 1, 0, 32'h0, 1);
        applyStimulus("sim full", 1, 1, 1, 0, 32'h0, 0);
        for (int k = 0; k < 4; k++) begin
            applyStimulus($sformatf("sim drain%0d", k), 0, 0, 0, 1, 32'hb0000000 + 32'(k), 0);
        end
        applyStimulus("sim spur", 0, 0, 0, 1, 32'hffffffff, 0);

        // Reset mid-operation: three outstanding and locked on instruction
        for (int k = 0; k < 3; k++) begin
            iAddr = 32'h1c002000 + 32'(4 * k);
            applyStimulus($sformatf("rst push%0d", k), 1, 0, 1, 0, 32'h0, 1);
        end
        applyStimulus("rst lock0", 1, 0, 0, 0, 32'h0, 1);
        applyStimulus("rst lock1", 1, 1, 0, 0, 32'h0, 1);
        bus.inst_req = 1'b1; bus.data_req = 1'b1;
        bus.mem_addr_ok = 1'b1; bus.mem_data_ok = 1'b1;
        #2;
        resetn = 1'b0;
        #1;
        checkResetOutputs("rst async");
        sbOwner.delete();
        clearInputs();
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        dAddr = 32'h1c080100; iAddr = 32'h1c003000;
        applyStimulus("rst post spur", 0, 0, 0, 1, 32'h01010101, 0);
        applyStimulus("rst post c0", 1, 1, 1, 0, 32'h0, 2);
        applyStimulus("rst post c1", 1, 0, 1, 0, 32'h0, 1);
        applyStimulus("rst post r0", 0, 0, 0, 1, 32'h02020202, 0);
        applyStimulus("rst post r1", 0, 0, 0, 1, 32'h03030303, 0);
        applyStimulus("rst post spur2", 0, 0, 0, 1, 32'h04040404, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/mem_req_arbiter.md
# mem_req_arbiter

Shares one SRAM-like memory port with the CPU's two requesters: instruction fetch (IF) and data access (MEM). Each requester uses the req/addr_ok/data_ok split-transaction handshake. The block grants the address channel to one requester at a time, holding the grant until the address handshake completes. It tracks outstanding transactions in an owner FIFO so that in-order read responses are steered back to the correct requester. It sits between the pipeline's fetch/memory stages and the memory-side bridge.

## Interface
- OUTST_DEPTH, 4, maximum outstanding (address-accepted, data-not-returned) transactions; power of two, ≥2
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- inst_req / data_req  in  1  requester asserts a transaction
- inst_wr / data_wr  in  1  1 = write, 0 = read
- inst_size / data_size  in  2  0: byte, 1: half, 2: word
- inst_wstrb / data_wstrb  in  4  byte write strobes
- inst_addr / data_addr  in  32  address
- inst_wdata / data_wdata  in  32  write data
- inst_addr_ok / data_addr_ok  out  1  address accepted for this requester
- inst_data_ok / data_data_ok  out  1  response for this requester's oldest transaction
- inst_rdata / data_rdata  out  32  read data (mem_rdata broadcast)
- mem_req, mem_wr, mem_size[1:0], mem_wstrb[3:0], mem_addr[31:0], mem_wdata[31:0]  out  shared port request, muxed from the granted requester
- mem_addr_ok  in  1  downstream accepted the address
- mem_data_ok  in  1  downstream response (in order)
- mem_rdata  in  32  downstream read data

## Operation
- States: IDLE, LOCK_I, LOCK_D.
- Grant in IDLE:
  - Requires cnt < OUTST_DEPTH.
  - Strict priority: data_req wins over inst_req.
  - The grant is combinational. mem_* is driven from the winner in the same cycle.
- In IDLE with a grant:
  - mem_addr_ok=1: handshake completes, stay IDLE.
  - mem_addr_ok=0: go to LOCK_I or LOCK_D. The winner is latched.
- In LOCK_x:
  - mem_* is driven only from requester x. The other requester sees addr_ok=0.
  - mem_addr_ok=1 → IDLE.
  - Requesters must hold req and payload stable until addr_ok. This is a protocol rule, not checked.
- Address handshake (mem_req & mem_addr_ok):
  - Owner's addr_ok=1.
  - Owner bit (0=I, 1=D) is pushed into the owner FIFO.
  - cnt increments.
- Response (mem_data_ok & cnt≠0):
  - data_ok goes to the owner at the FIFO head.
  - FIFO pops; cnt decrements.
  - rdata is broadcast to both requesters regardless.
- mem_data_ok with cnt==0: ignored. No pop, no data_ok to either requester.
- Simultaneous push and pop:
  - Pop uses the pre-push head.
  - cnt is unchanged.
  - Pointers wrap modulo OUTST_DEPTH.
- Full (cnt==OUTST_DEPTH): mem_req=0 and both addr_ok=0 until a pop. A same-cycle pop does not unblock a grant; the grant uses the registered cnt.
- cnt width: clog2(OUTST_DEPTH)+1 bits, range 0..OUTST_DEPTH.
- Pipeline exception/ertn flush: no cancellation here. Requesters discard unwanted data_ok themselves. The arbiter always returns every response to its owner.
- Reset (async, any time):
  - State IDLE, cnt=0, FIFO pointers 0. In-flight transactions are forgotten; downstream is reset on the same resetn.
  - Output reset values: mem_req=0, all addr_ok=0, all data_ok=0.
  - All other outputs are don't-care while mem_req=0.

## Timing
- Zero added latency:
  - addr_ok to a requester is combinational from mem_addr_ok and the grant.
  - data_ok is combinational from mem_data_ok and the FIFO head.
- State, cnt and FIFO update on the posedge of clk.
- Back-to-back grants are allowed every cycle while downstream accepts and cnt < OUTST_DEPTH.
- Downstream must not return data_ok in the same cycle as the addr_ok of that transaction.
- Strict data priority can starve IF. This is accepted: a MEM-stage stall drains the data requests.

## Test plan
- Single read: inst_req with addr 0x1c000000, mem_addr_ok=1 in cycle 0, then mem_data_ok with rdata 0x02800404 in cycle 2. Required: inst_addr_ok=1 in cycle 0, inst_data_ok=1 with inst_rdata=0x02800404 in cycle 2, data_data_ok=0 throughout, cnt back to 0.
- Contention: inst_req and data_req both asserted, data_addr 0x1c080000, wr=1, wstrb=0xf. Required: mem_addr=0x1c080000 granted first. Inst is granted on the next cycle. Two in-order data_ok responses go to D then I.
- Lock hold: data_req granted with mem_addr_ok=0 for 3 cycles while inst_req rises. Required: mem_addr stays the data address, state LOCK_D, inst_addr_ok=0. Inst is granted only after the data addr_ok.
- Full: OUTST_DEPTH=4 accepted with no responses, then a 5th inst_req. Required: mem_req=0 until the first mem_data_ok; the grant occurs the following cycle. Pointer wrap is verified over 10 transactions.
- Simultaneous push and pop at cnt=2: Required: cnt stays 2, and the popped owner is the oldest. Spurious mem_data_ok at cnt=0 produces no data_ok.
- Reset mid-operation: resetn low with cnt=3 in LOCK_I. Required: mem_req=0, addr_ok/data_ok=0 immediately (asynchronous), then clean operation from IDLE after release.
